// File: rtl/branch_resolve_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_queue_if
// Brief    : Predict / resolve / update bundle between the front-end and the
//            branch resolve queue.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_resolve_queue_if #(
    parameter int K     = 4,
    parameter int M     = 4,
    parameter int DEPTH = 8
);
    localparam int c_OW = $clog2(DEPTH) + 1;

    logic              pred_valid;
    logic [K-1:0]      pred_index;
    logic              pred_taken;
    logic              pred_ready;
    logic [M-1:0]      spec_bhr;
    logic              res_valid;
    logic              res_taken;
    logic              upd_valid;
    logic [K-1:0]      upd_index;
    logic [M-1:0]      upd_bhr;
    logic              upd_outcome;
    logic              mispredict;
    logic [c_OW-1:0]   occupancy;
    logic              res_err;
    logic [15:0]       mispred_count;

    modport master (
        output pred_valid, pred_index, pred_taken, res_valid, res_taken,
        input  pred_ready, spec_bhr, upd_valid, upd_index, upd_bhr,
               upd_outcome, mispredict, occupancy, res_err, mispred_count
    );

    modport slave (
        input  pred_valid, pred_index, pred_taken, res_valid, res_taken,
        output pred_ready, spec_bhr, upd_valid, upd_index, upd_bhr,
               upd_outcome, mispredict, occupancy, res_err, mispred_count
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_queue
// Brief    : In-order queue of predicted branches; owns the speculative and
//            architectural global history and drives predictor updates.
//            Optional macro BRQ_MISPRED_CNT_EN enables the mispredict counter.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_queue #(
    parameter int K     = 4,
    parameter int M     = 4,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_queue_if.slave brq
);
    localparam int              c_PW    = $clog2(DEPTH);
    localparam int              c_OW    = c_PW + 1;
    localparam logic [c_OW-1:0] c_FULL  = c_OW'(DEPTH);
    localparam logic [c_OW-1:0] c_ZERO  = '0;

    logic [K-1:0]    r_idx_mem   [DEPTH];
    logic [M-1:0]    r_snap_mem  [DEPTH];
    logic            r_ptkn_mem  [DEPTH];

    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_OW-1:0] r_count;
    logic [M-1:0]    r_spec_bhr;
    logic [M-1:0]    r_arch_bhr;
    logic            r_upd_valid;
    logic [K-1:0]    r_upd_index;
    logic [M-1:0]    r_upd_bhr;
    logic            r_upd_outcome;
    logic            r_mispredict;
    logic            r_res_err;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_mis;
    logic [M-1:0]    w_arch_next;

    assign w_full      = (r_count == c_FULL);
    assign w_push      = brq.pred_valid && !w_full;
    assign w_pop       = brq.res_valid && (r_count != c_ZERO);
    assign w_mis       = w_pop && (brq.res_taken != r_ptkn_mem[r_head]);
    assign w_arch_next = {r_arch_bhr[M-2:0], brq.res_taken};

    // Entry storage carries no reset: validity is tracked by head/tail/count.
    always_ff @(posedge clk) begin
        if (w_push && !w_mis) begin
            r_idx_mem[r_tail]  <= brq.pred_index;
            r_snap_mem[r_tail] <= r_spec_bhr;
            r_ptkn_mem[r_tail] <= brq.pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_spec_bhr    <= '0;
            r_arch_bhr    <= '0;
            r_upd_valid   <= 1'b0;
            r_upd_index   <= '0;
            r_upd_bhr     <= '0;
            r_upd_outcome <= 1'b0;
            r_mispredict  <= 1'b0;
            r_res_err     <= 1'b0;
        end else begin
            r_upd_valid  <= w_pop;
            r_mispredict <= w_mis;

            if (brq.res_valid && (r_count == c_ZERO)) begin
                r_res_err <= 1'b1;
            end

            if (w_pop) begin
                r_upd_index   <= r_idx_mem[r_head];
                r_upd_bhr     <= r_snap_mem[r_head];
                r_upd_outcome <= brq.res_taken;
                r_arch_bhr    <= w_arch_next;
                r_head        <= r_head + 1'b1;
            end

            // A flush drops every younger entry and any push arriving with it.
            if (w_mis) begin
                r_count    <= '0;
                r_tail     <= r_head + 1'b1;
                r_spec_bhr <= w_arch_next;
            end else begin
                r_count <= r_count + {{(c_OW-1){1'b0}}, w_push}
                                   - {{(c_OW-1){1'b0}}, w_pop};
                if (w_push) begin
                    r_tail     <= r_tail + 1'b1;
                    r_spec_bhr <= {r_spec_bhr[M-2:0], brq.pred_taken};
                end
            end
        end
    end

`ifdef BRQ_MISPRED_CNT_EN
    logic [15:0] r_mis_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mis_cnt <= '0;
        end else if (w_mis && (r_mis_cnt != 16'hFFFF)) begin
            r_mis_cnt <= r_mis_cnt + 16'd1;
        end
    end

    assign brq.mispred_count = r_mis_cnt;
`else
    assign brq.mispred_count = 16'h0000;
`endif

    assign brq.pred_ready  = !w_full;
    assign brq.spec_bhr    = r_spec_bhr;
    assign brq.occupancy   = r_count;
    assign brq.upd_valid   = r_upd_valid;
    assign brq.upd_index   = r_upd_index;
    assign brq.upd_bhr     = r_upd_bhr;
    assign brq.upd_outcome = r_upd_outcome;
    assign brq.mispredict  = r_mispredict;
    assign brq.res_err     = r_res_err;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_queue
// Brief    : Directed vector table plus a fill/drain sequence for the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_queue;
`ifdef BRQ_MISPRED_CNT_EN
    localparam int c_MC1 = 1;
`else
    localparam int c_MC1 = 0;
`endif

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    branch_resolve_queue_if #(.K(4), .M(4), .DEPTH(8)) bif ();

    branch_resolve_queue #(.K(4), .M(4), .DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .brq   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst_n, pv;
        logic [3:0]  pi;
        logic        pt, rv, rt;
        logic        rdy;
        logic [3:0]  occ, sb;
        logic        uv;
        logic [3:0]  ui, ub;
        logic        uo, mp, err;
        logic [15:0] mc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(int rst_n, int pv, int pi, int pt, int rv, int rt,
                                int rdy, int occ, int sb, int uv, int ui, int ub,
                                int uo, int mp, int err, int mc);
        vec_t v;
        v.rst_n = 1'(rst_n); v.pv = 1'(pv); v.pi = 4'(pi); v.pt = 1'(pt);
        v.rv = 1'(rv); v.rt = 1'(rt); v.rdy = 1'(rdy); v.occ = 4'(occ);
        v.sb = 4'(sb); v.uv = 1'(uv); v.ui = 4'(ui); v.ub = 4'(ub);
        v.uo = 1'(uo); v.mp = 1'(mp); v.err = 1'(err); v.mc = 16'(mc);
        return v;
    endfunction

    task automatic chk(input string nm, input int vi, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, vi, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic pv, input logic [3:0] pi,
                         input logic pt, input logic rv, input logic rt);
        reset          = rst_n;
        bif.pred_valid = pv;
        bif.pred_index = pi;
        bif.pred_taken = pt;
        bif.res_valid  = rv;
        bif.res_taken  = rt;
    endtask

    logic [3:0] snap_exp [8];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        //           rst pv pi pt rv rt | rdy occ sb uv ui ub uo mp err mc
        tv.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 3, 1, 0, 0,  1, 1, 1,  0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 5, 0, 0, 0,  1, 2, 2,  0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 1, 1,  1, 1, 2,  1, 3, 0, 1, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 1, 0,  1, 0, 2,  1, 5, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 2,  0, 5, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 8, 1, 0, 0,  1, 1, 5,  0, 5, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 9, 1, 0, 0,  1, 2, 11, 0, 5, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 10, 1, 0, 0, 1, 3, 7,  0, 5, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 11, 1, 0, 0, 1, 4, 15, 0, 5, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 12, 1, 0, 0, 1, 5, 15, 0, 5, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 13, 1, 0, 0, 1, 6, 15, 0, 5, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 14, 1, 0, 0, 1, 7, 15, 0, 5, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 15, 1, 0, 0, 0, 8, 15, 0, 5, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 6, 0, 0, 0,  0, 8, 15, 0, 5, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 1, 1,  1, 7, 15, 1, 8, 2, 1, 0, 0, 0));
        tv.push_back(mk(1, 1, 6, 0, 1, 1,  1, 7, 14, 1, 9, 5, 1, 0, 0, 0));
        tv.push_back(mk(1, 1, 7, 1, 0, 0,  0, 8, 13, 0, 9, 5, 1, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 1, 1,  1, 7, 13, 1, 10, 11, 1, 0, 0, 0));
        tv.push_back(mk(1, 1, 2, 1, 1, 0,  1, 0, 14, 1, 11, 7, 0, 1, 0, c_MC1));
        tv.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 14, 0, 11, 7, 0, 0, 0, c_MC1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 0,  1, 1, 1,  0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 2, 1, 0, 0,  1, 2, 3,  0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 3, 1, 0, 0,  1, 3, 7,  0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 4, 1, 0, 0,  1, 4, 15, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 9, 1, 1, 0,  1, 0, 0,  1, 1, 0, 0, 1, 0, c_MC1));
        tv.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 0,  0, 1, 0, 0, 0, 0, c_MC1));
        tv.push_back(mk(1, 0, 0, 0, 1, 0,  1, 0, 0,  0, 1, 0, 0, 0, 1, c_MC1));
        tv.push_back(mk(1, 1, 3, 1, 1, 1,  1, 1, 1,  0, 1, 0, 0, 0, 1, c_MC1));
        tv.push_back(mk(1, 0, 0, 0, 0, 0,  1, 1, 1,  0, 1, 0, 0, 0, 1, c_MC1));
        tv.push_back(mk(1, 1, 10, 1, 0, 0, 1, 2, 3,  0, 1, 0, 0, 0, 1, c_MC1));
        tv.push_back(mk(1, 1, 11, 1, 0, 0, 1, 3, 7,  0, 1, 0, 0, 0, 1, c_MC1));
        tv.push_back(mk(1, 1, 12, 1, 0, 0, 1, 4, 15, 0, 1, 0, 0, 0, 1, c_MC1));
        tv.push_back(mk(1, 1, 13, 1, 0, 0, 1, 5, 15, 0, 1, 0, 0, 0, 1, c_MC1));
        tv.push_back(mk(0, 1, 6, 1, 1, 1,  1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 4, 1, 0, 0,  1, 1, 1,  0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            drive(tv[i].rst_n, tv[i].pv, tv[i].pi, tv[i].pt, tv[i].rv, tv[i].rt);
            @(posedge clk);
            #1;
            chk("pred_ready",    i, 32'(bif.pred_ready),    32'(tv[i].rdy));
            chk("occupancy",     i, 32'(bif.occupancy),     32'(tv[i].occ));
            chk("spec_bhr",      i, 32'(bif.spec_bhr),      32'(tv[i].sb));
            chk("upd_valid",     i, 32'(bif.upd_valid),     32'(tv[i].uv));
            chk("upd_index",     i, 32'(bif.upd_index),     32'(tv[i].ui));
            chk("upd_bhr",       i, 32'(bif.upd_bhr),       32'(tv[i].ub));
            chk("upd_outcome",   i, 32'(bif.upd_outcome),   32'(tv[i].uo));
            chk("mispredict",    i, 32'(bif.mispredict),    32'(tv[i].mp));
            chk("res_err",       i, 32'(bif.res_err),       32'(tv[i].err));
            chk("mispred_count", i, 32'(bif.mispred_count), 32'(tv[i].mc));
        end

        // Fill to full after index 4, then drain back-to-back in order.
        for (int i = 5; i <= 11; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("full_ready", 100, 32'(bif.pred_ready), 32'd0);
        chk("full_occ",   100, 32'(bif.occupancy),  32'd8);
        chk("full_bhr",   100, 32'(bif.spec_bhr),   32'hF);

        // Inputs changing mid-cycle must not reach pred_ready/occupancy.
        drive(1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1);
        #1;
        chk("comb_ready", 101, 32'(bif.pred_ready), 32'd0);
        chk("comb_occ",   101, 32'(bif.occupancy),  32'd8);
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);

        snap_exp[0] = 4'h0; snap_exp[1] = 4'h1; snap_exp[2] = 4'h3; snap_exp[3] = 4'h7;
        snap_exp[4] = 4'hF; snap_exp[5] = 4'hF; snap_exp[6] = 4'hF; snap_exp[7] = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("drain_valid", 200 + i, 32'(bif.upd_valid),  32'd1);
            chk("drain_index", 200 + i, 32'(bif.upd_index),  32'(4 + i));
            chk("drain_bhr",   200 + i, 32'(bif.upd_bhr),    32'(snap_exp[i]));
            chk("drain_mis",   200 + i, 32'(bif.mispredict), 32'd0);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("drain_end_valid", 300, 32'(bif.upd_valid), 32'd0);
        chk("drain_end_occ",   300, 32'(bif.occupancy), 32'd0);
        chk("drain_end_err",   300, 32'(bif.res_err),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Tracks every branch the front-end has predicted until it resolves, and drives the predictor's update side. Holds a speculative global history register (BHR) that supplies the predictor's history input, snapshots that history per branch, and returns {index, history, actual outcome} to the predictor's pattern table in program order. On a misprediction it flushes all younger in-flight branches and repairs the speculative BHR from the architectural one. Sits between fetch/predict and the execute-stage branch resolution logic.

## Interface
- K, 4, branch PC index width (matches predictor index)
- M, 4, global history width (matches predictor history input)
- DEPTH, 8, in-flight branch entries; power of two, ≥2
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- pred_valid  in  1  a branch was predicted this cycle
- pred_index  in  K  PC index of that branch
- pred_taken  in  1  predicted direction
- pred_ready  out  1  queue can accept (= not full)
- spec_bhr  out  M  speculative history for the predictor's history input
- res_valid  in  1  oldest in-flight branch resolved this cycle
- res_taken  in  1  actual direction
- upd_valid  out  1  registered predictor-update strobe
- upd_index  out  K  index of resolved branch
- upd_bhr  out  M  history snapshot taken when that branch was predicted
- upd_outcome  out  1  actual direction
- mispredict  out  1  registered one-cycle flush pulse
- occupancy  out  $clog2(DEPTH)+1  entries in flight
- res_err  out  1  sticky: res_valid seen while empty
- mispred_count  out  16  saturating misprediction count

## Operation
- Entry = {index, bhr snapshot, pred_taken}. Circular buffer, head/tail pointers with wrap at DEPTH; separate occupancy counter.
- Push accepted when pred_valid && pred_ready: entry written at tail with snapshot = current spec_bhr; spec_bhr <= {spec_bhr[M-2:0], pred_taken}.
- pred_valid with pred_ready low: dropped, no state change.
- Resolve accepted when res_valid && occupancy != 0 (includes same-cycle push into empty queue: not accepted, push wins, resolve is error). Head entry popped; arch_bhr <= {arch_bhr[M-2:0], res_taken}; upd_* loaded from head entry with upd_outcome = res_taken.
- res_valid while empty: ignored, res_err set and held until reset.
- Mispredict = accepted resolve with res_taken != head.pred_taken. Then: all remaining entries discarded (occupancy <= 0, tail <= head+1), any same-cycle push also discarded, spec_bhr <= new arch_bhr value ({arch_bhr[M-2:0], res_taken}).
- Correct resolve with simultaneous push: both occur, occupancy unchanged.
- Arithmetic: pointers modulo DEPTH; occupancy never exceeds DEPTH or goes below 0.

## Timing
- Reset (reset low at clk edge): occupancy 0, pointers 0, spec_bhr/arch_bhr 0, upd_valid 0, upd_index/upd_bhr/upd_outcome 0, mispredict 0, res_err 0, mispred_count 0; pred_ready 1 after reset. Reset mid-operation discards all entries.
- pred_ready, occupancy, spec_bhr are registered-state derived; no combinational path from pred_valid/res_valid.
- spec_bhr reflects a push on the cycle after it.
- upd_valid/upd_* and mispredict assert exactly one cycle after the accepted resolve, for one cycle.
- Back-to-back resolves produce back-to-back upd_valid.
- Flush effect on pred_ready/occupancy visible the cycle after the mispredicting resolve.

## Configuration
- BRQ_MISPRED_CNT_EN defined: mispred_count increments by 1 on each mispredict, saturates at 16'hFFFF, cleared only by reset.
- Not defined: counter logic absent, mispred_count tied to 0. All other behaviour identical.

## Test plan
- Reset then push index 3 taken, index 5 not-taken with spec_bhr 0 -> snapshots 0000 and 0001, spec_bhr 0010, occupancy 2.
- Resolve both correctly (taken, not-taken) -> upd_valid two consecutive cycles: {3,0000,1} then {5,0001,0}; mispredict never asserts; occupancy 0.
- Push 8 branches -> pred_ready 0; 9th push dropped; resolve one while pushing -> occupancy stays 8 after refill, tail wraps to 0 correctly.
- Push 4 branches (all predicted taken), resolve first not-taken -> mispredict pulse next cycle, occupancy 0, spec_bhr = arch history 0000, same-cycle push discarded, mispred_count 1 (macro on) / 0 (macro off).
- res_valid with empty queue -> no upd_valid, res_err 1 and stays 1 until reset low.
- Assert reset with 5 entries in flight and a resolve pending -> next cycle all outputs at reset values, pred_ready 1.
